// File: rtl/router_qw_pkg.sv
// Shared definitions for the queued-write data-bank router: write-mode encodings
// and the width of one pending-write queue entry.
package router_qw_pkg;

  typedef enum logic [1:0] {
    SW_DIRECT  = 2'd0,
    SW_QUEUED  = 2'd1,
    SW_INHIBIT = 2'd2,
    SW_FORCE   = 2'd3
  } sw_mode_e;

  // Queue entry is {data word, write address}.
  function automatic int entry_w(input int w, input int addrw);
    return w + addrw;
  endfunction

endpackage

// File: rtl/router_wq.sv
// Synchronous pending-write FIFO. It accepts a push and a pop in the same cycle,
// even when full. A push into a full queue with no pop is ignored.
module router_wq #(
  parameter int DW    = 29,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] cnt_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign cnt_o   = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/router_qw.sv
// Data-bank router: selects a source word and addresses, then issues writes either
// directly or through a pending-write queue that drains while the bank is READY.
module router_qw
  import router_qw_pkg::*;
#(
  parameter int W     = 24,
  parameter int ADDRW = 5,
  parameter int NSRC  = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NSRC*W-1:0]          SRC_DATA,
  input  logic [$clog2(NSRC+1)-1:0]  sel_data,
  input  logic [ADDRW-1:0]           CTL_A,
  input  logic [ADDRW-1:0]           CTL_B,
  input  logic [ADDRW-1:0]           DIR_EXT,
  input  logic                       sel_dira,
  input  logic                       sel_dirb,
  input  logic                       WRITE_REQ,
  input  logic                       READY,
  input  logic [1:0]                 sel_write,
  output logic [W-1:0]               db_data,
  output logic [ADDRW-1:0]           db_dira,
  output logic [ADDRW-1:0]           db_dirb,
  output logic                       db_write,
  output logic [$clog2(DEPTH):0]     PEND_CNT,
  output logic                       FULL,
  output logic                       OVF
);
  localparam int SELW = $clog2(NSRC + 1);
  localparam int EW   = entry_w(W, ADDRW);
  localparam int CW   = $clog2(DEPTH) + 1;

  sw_mode_e         mode;
  logic [W-1:0]     cand_data;
  logic [ADDRW-1:0] wr_addr, rd_addr;
  logic             q_push, q_pop, q_full, q_empty, bypass;
  logic [EW-1:0]    q_dout;
  logic [CW-1:0]    q_cnt;

  logic [W-1:0]     data_q, data_d;
  logic [ADDRW-1:0] dira_q, dira_d, dirb_q;
  logic             write_q, write_d, ovf_q, ovf_d;

  assign mode = sw_mode_e'(sel_write);

  // Select values above NSRC fall back to source 0; NSRC itself selects a zero word.
  always_comb begin
    cand_data = SRC_DATA[W-1:0];
    for (int k = 1; k < NSRC; k++)
      if (sel_data == SELW'(k)) cand_data = SRC_DATA[k*W +: W];
    if (sel_data == SELW'(NSRC)) cand_data = '0;
  end

  assign wr_addr = sel_dira ? DIR_EXT : CTL_A;
  assign rd_addr = sel_dirb ? DIR_EXT : CTL_B;

  // The head of the queue always beats a new request, which keeps writes in request order.
  always_comb begin
    q_pop  = (mode == SW_QUEUED) && READY && !q_empty;
    bypass = (mode == SW_QUEUED) && READY && WRITE_REQ && q_empty;
    q_push = (mode == SW_QUEUED) && WRITE_REQ && !bypass;
    ovf_d  = ovf_q | (q_push && q_full && !q_pop);
  end

  always_comb begin
    data_d  = data_q;
    dira_d  = dira_q;
    write_d = 1'b0;
    case (mode)
      SW_DIRECT: begin
        write_d = WRITE_REQ;
        data_d  = cand_data;
        dira_d  = wr_addr;
      end
      SW_FORCE: begin
        write_d = 1'b1;
        data_d  = cand_data;
        dira_d  = wr_addr;
      end
      SW_QUEUED: begin
        if (q_pop) begin
          write_d          = 1'b1;
          {data_d, dira_d} = q_dout;
        end else if (bypass) begin
          write_d = 1'b1;
          data_d  = cand_data;
          dira_d  = wr_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q  <= '0;
      dira_q  <= '0;
      dirb_q  <= '0;
      write_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      dira_q  <= dira_d;
      dirb_q  <= rd_addr;
      write_q <= write_d;
      ovf_q   <= ovf_d;
    end
  end

  router_wq #(.DW(EW), .DEPTH(DEPTH), .CW(CW)) u_wq (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .din_i   ({cand_data, wr_addr}),
    .dout_o  (q_dout),
    .full_o  (q_full),
    .empty_o (q_empty),
    .cnt_o   (q_cnt)
  );

  assign db_data  = data_q;
  assign db_dira  = dira_q;
  assign db_dirb  = dirb_q;
  assign db_write = write_q;
  assign PEND_CNT = q_cnt;
  assign FULL     = q_full;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_router_qw.sv
// Directed bench for router_qw. Every expected bank write goes into a scoreboard
// queue, and each db_write pulse pops one entry and compares against it.
module tb_router_qw;
  localparam int W = 24, ADDRW = 5, NSRC = 4, DEPTH = 4;

  typedef struct {
    logic [W-1:0]     data;
    logic [ADDRW-1:0] addr;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NSRC*W-1:0] SRC_DATA;
  logic [2:0]        sel_data;
  logic [ADDRW-1:0]  CTL_A, CTL_B, DIR_EXT;
  logic              sel_dira, sel_dirb, WRITE_REQ, READY;
  logic [1:0]        sel_write;
  logic [W-1:0]      db_data;
  logic [ADDRW-1:0]  db_dira, db_dirb;
  logic              db_write;
  logic [2:0]        PEND_CNT;
  logic              FULL, OVF;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  router_qw #(.W(W), .ADDRW(ADDRW), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .SRC_DATA(SRC_DATA), .sel_data(sel_data),
    .CTL_A(CTL_A), .CTL_B(CTL_B), .DIR_EXT(DIR_EXT),
    .sel_dira(sel_dira), .sel_dirb(sel_dirb), .WRITE_REQ(WRITE_REQ), .READY(READY),
    .sel_write(sel_write), .db_data(db_data), .db_dira(db_dira), .db_dirb(db_dirb),
    .db_write(db_write), .PEND_CNT(PEND_CNT), .FULL(FULL), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge. Any write pulse must match the scoreboard head.
  task automatic step();
    exp_t e;
    @(posedge CLK);
    #1;
    if (db_write === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_write", {31'd0, db_write}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("wr_data", {8'd0, db_data}, {8'd0, e.data});
        chk("wr_addr", {27'd0, db_dira}, {27'd0, e.addr});
      end
    end
  endtask

  task automatic set_src(input int k, input logic [W-1:0] v);
    SRC_DATA[k*W +: W] = v;
  endtask

  task automatic expect_wr(input logic [W-1:0] d, input logic [ADDRW-1:0] a);
    exp_t e;
    e.data = d;
    e.addr = a;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    WRITE_REQ = 1'b0;
    sb.delete();
    step();
    RST = 1'b0;
  endtask

  task automatic chk_q(input string tag, input int pend, input logic full, input logic ovf);
    chk({tag, "_pend"}, {29'd0, PEND_CNT}, pend);
    chk({tag, "_full"}, {31'd0, FULL}, {31'd0, full});
    chk({tag, "_ovf"},  {31'd0, OVF},  {31'd0, ovf});
  endtask

  initial begin
    SRC_DATA = '0; sel_data = 3'd0; CTL_A = '0; CTL_B = '0; DIR_EXT = '0;
    sel_dira = 1'b0; sel_dirb = 1'b0; WRITE_REQ = 1'b0; READY = 1'b0; sel_write = 2'd0;
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    chk("rst_data", {8'd0, db_data}, 32'd0);
    chk("rst_dira", {27'd0, db_dira}, 32'd0);
    chk("rst_dirb", {27'd0, db_dirb}, 32'd0);
    chk("rst_write", {31'd0, db_write}, 32'd0);
    chk_q("rst", 0, 1'b0, 1'b0);

    // Mode 0 direct write from source 2
    set_src(2, 24'h00ABCD); sel_data = 3'd2; CTL_A = 5'd5; WRITE_REQ = 1'b1; sel_write = 2'd0;
    expect_wr(24'h00ABCD, 5'd5);
    step();
    WRITE_REQ = 1'b0;
    step();
    chk("m0_idle_write", {31'd0, db_write}, 32'd0);
    // An out-of-range select falls back to source 0
    set_src(0, 24'h0F0F0F); sel_data = 3'd6; CTL_A = 5'd9; WRITE_REQ = 1'b1;
    expect_wr(24'h0F0F0F, 5'd9);
    step();
    WRITE_REQ = 1'b0;
    step();
    chk("sb_m0", sb.size(), 32'd0);

    // Mode 1: three queued writes, then drain
    sel_write = 2'd1; READY = 1'b0; sel_data = 3'd0; WRITE_REQ = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_src(0, 24'(i * 'h11)); CTL_A = 5'(i);
      expect_wr(24'(i * 'h11), 5'(i));
      step();
    end
    WRITE_REQ = 1'b0;
    chk_q("q3", 3, 1'b0, 1'b0);
    chk("q3_write", {31'd0, db_write}, 32'd0);
    READY = 1'b1;
    step(); step(); step();
    chk_q("drain3", 0, 1'b0, 1'b0);
    chk("sb_drain3", sb.size(), 32'd0);
    step();
    chk("drain3_idle", {31'd0, db_write}, 32'd0);

    // Bypass: empty queue, READY, request goes straight out
    set_src(0, 24'h777777); CTL_A = 5'd17; WRITE_REQ = 1'b1;
    expect_wr(24'h777777, 5'd17);
    step();
    WRITE_REQ = 1'b0;
    chk_q("bypass", 0, 1'b0, 1'b0);
    chk("sb_bypass", sb.size(), 32'd0);

    // Overflow: five writes into a 4-deep queue
    READY = 1'b0; WRITE_REQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_src(0, 24'(24'h100 + i)); CTL_A = 5'(10 + i);
      if (i < 4) expect_wr(24'(24'h100 + i), 5'(10 + i));
      step();
      if (i == 3) chk_q("full4", 4, 1'b1, 1'b0);
    end
    WRITE_REQ = 1'b0;
    chk_q("ovf", 4, 1'b1, 1'b1);
    READY = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("sb_ovf_drain", sb.size(), 32'd0);
    chk_q("ovf_drained", 0, 1'b0, 1'b1);

    // Simultaneous pop and push while full
    do_reset();
    sel_write = 2'd1; READY = 1'b0; WRITE_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_src(0, 24'(24'h200 + i)); CTL_A = 5'(20 + i);
      expect_wr(24'(24'h200 + i), 5'(20 + i));
      step();
    end
    chk_q("pp_full", 4, 1'b1, 1'b0);
    READY = 1'b1; set_src(0, 24'h000555); CTL_A = 5'd24;
    expect_wr(24'h000555, 5'd24);
    step();
    WRITE_REQ = 1'b0;
    chk_q("pp", 4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("sb_pp", sb.size(), 32'd0);
    chk_q("pp_drained", 0, 1'b0, 1'b0);

    // Pending entries survive a mode change and drain when mode 1 returns
    READY = 1'b0; WRITE_REQ = 1'b1;
    set_src(0, 24'h0000A1); CTL_A = 5'd3; expect_wr(24'h0000A1, 5'd3); step();
    set_src(0, 24'h0000A2); CTL_A = 5'd4; expect_wr(24'h0000A2, 5'd4); step();
    WRITE_REQ = 1'b0; sel_write = 2'd2; READY = 1'b1;
    step(); step();
    chk("inh_write", {31'd0, db_write}, 32'd0);
    chk_q("inh", 2, 1'b0, 1'b0);
    sel_write = 2'd1;
    step(); step();
    chk("sb_resume", sb.size(), 32'd0);
    chk_q("resume", 0, 1'b0, 1'b0);

    // Reset in the middle of a drain discards the pending entries
    READY = 1'b0; WRITE_REQ = 1'b1;
    set_src(0, 24'h0000B1); CTL_A = 5'd6; step();
    set_src(0, 24'h0000B2); CTL_A = 5'd7; step();
    chk_q("pre_rst", 2, 1'b0, 1'b0);
    READY = 1'b1;
    do_reset();
    chk("rst2_data", {8'd0, db_data}, 32'd0);
    chk("rst2_dira", {27'd0, db_dira}, 32'd0);
    chk("rst2_write", {31'd0, db_write}, 32'd0);
    chk_q("rst2", 0, 1'b0, 1'b0);
    step();
    chk("post_rst_write", {31'd0, db_write}, 32'd0);
    step();
    chk("post_rst_write2", {31'd0, db_write}, 32'd0);

    // Force mode with the zero word; read address taken from DIR_EXT
    sel_data = 3'd4; set_src(0, 24'hFFFFFF); sel_write = 2'd3; WRITE_REQ = 1'b0;
    CTL_A = 5'd7; sel_dirb = 1'b1; DIR_EXT = 5'd31; CTL_B = 5'd2;
    expect_wr(24'h000000, 5'd7);
    step();
    chk("force_dirb", {27'd0, db_dirb}, 32'd31);
    // Inhibit holds data and address while the read address still tracks its mux
    sel_write = 2'd2; sel_data = 3'd0; CTL_A = 5'd12; sel_dirb = 1'b0; WRITE_REQ = 1'b1;
    step();
    chk("inh2_write", {31'd0, db_write}, 32'd0);
    chk("inh2_data", {8'd0, db_data}, 32'd0);
    chk("inh2_dira", {27'd0, db_dira}, 32'd7);
    chk("inh2_dirb", {27'd0, db_dirb}, 32'd2);
    chk("sb_final", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
